// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master transfer port among
// NUM_REQ requesters. One transfer in flight at a time. Completion is observed on
// the APB bus, and a watchdog forces an error response if a transfer stalls.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]   req_strb,
  input  logic [NUM_REQ*3-1:0]   req_prot,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   SWRITE,
  output logic [31:0]            SADDR,
  output logic [31:0]            SWDATA,
  output logic [3:0]             SSTRB,
  output logic [2:0]             SPROT,
  output logic                   transfer,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PREADY,
  input  logic                   PSLVERR,
  input  logic [31:0]            PRDATA,
  output logic                   timeout_flag
);

  localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } cmd_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr, rr_n;
  logic [IDX_W-1:0]   gidx, gidx_n;
  logic [IDX_W-1:0]   gsel;
  logic               gfound;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand;
  logic [WD_W-1:0]    wd, wd_n;
  cmd_t               cmd, cmd_n, cmd_sel;
  logic               transfer_n;
  logic [NUM_REQ-1:0] rsp_valid_n;
  logic [31:0]        rdata_n;
  logic               err_n;
  logic               tflag_n;
  logic               done;

  assign done = PSEL & PENABLE & PREADY;

  // Round-robin search: first pending requester at or above rr, wrapping.
  always_comb begin
    gfound   = 1'b0;
    gsel     = '0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ)) cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      cand = cand_sum[IDX_W-1:0];
      if (!gfound && req_valid[cand]) begin
        gfound = 1'b1;
        gsel   = cand;
      end
    end
  end

  // Select the winning requester's command fields.
  always_comb begin
    cmd_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gsel == IDX_W'(k)) begin
        cmd_sel = {req_write[k], req_addr[32*k +: 32], req_wdata[32*k +: 32],
                   req_strb[4*k +: 4], req_prot[3*k +: 3]};
      end
    end
  end

  // Acceptance is combinational in IDLE; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (PRESETn && (state == IDLE) && gfound) req_ready = NUM_REQ'(1) << gsel;
  end

  // Next-state and registered-output next values.
  always_comb begin
    state_n     = state;
    rr_n        = rr;
    gidx_n      = gidx;
    wd_n        = wd;
    cmd_n       = cmd;
    transfer_n  = 1'b0;
    rsp_valid_n = '0;
    rdata_n     = rsp_rdata;
    err_n       = rsp_err;
    tflag_n     = timeout_flag;
    case (state)
      IDLE: begin
        if (gfound) begin
          cmd_n      = cmd_sel;
          gidx_n     = gsel;
          rr_n       = (gsel == IDX_W'(NUM_REQ-1)) ? '0 : gsel + 1'b1;
          transfer_n = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (done) begin
          rsp_valid_n = NUM_REQ'(1) << gidx;
          rdata_n     = cmd.write ? 32'h0 : PRDATA;
          err_n       = PSLVERR;
          state_n     = RESP;
        end else if (wd == WD_W'(TIMEOUT-1)) begin
          rsp_valid_n = NUM_REQ'(1) << gidx;
          rdata_n     = 32'h0;
          err_n       = 1'b1;
          tflag_n     = 1'b1;
          state_n     = RESP;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= IDLE;
      rr           <= '0;
      gidx         <= '0;
      wd           <= '0;
      cmd          <= '0;
      transfer     <= 1'b0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_n;
      rr           <= rr_n;
      gidx         <= gidx_n;
      wd           <= wd_n;
      cmd          <= cmd_n;
      transfer     <= transfer_n;
      rsp_valid    <= rsp_valid_n;
      rsp_rdata    <= rdata_n;
      rsp_err      <= err_n;
      timeout_flag <= tflag_n;
    end
  end

  assign SWRITE = cmd.write;
  assign SADDR  = cmd.addr;
  assign SWDATA = cmd.wdata;
  assign SSTRB  = cmd.strb;
  assign SPROT  = cmd.prot;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: simple APB slave model, scoreboard of expected
// responses pushed at acceptance and popped when rsp_valid appears.
module tb_apb_req_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned TO = 16;

  logic            PCLK;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N*4-1:0]  req_strb;
  logic [N*3-1:0]  req_prot;
  logic [31:0]     rsp_rdata, SADDR, SWDATA, PRDATA;
  logic            rsp_err, SWRITE, transfer, timeout_flag;
  logic [3:0]      SSTRB;
  logic [2:0]      SPROT;
  logic            PSEL, PENABLE, PREADY, PSLVERR;

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .SWRITE(SWRITE), .SADDR(SADDR), .SWDATA(SWDATA),
    .SSTRB(SSTRB), .SPROT(SPROT), .transfer(transfer),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA), .timeout_flag(timeout_flag)
  );

  typedef struct {
    int unsigned idx;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rdata;
    logic        err;
    int unsigned acc_cyc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned grants[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  logic        stall;
  exp_t        mon_e;
  int unsigned mon_g;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: compare responses and bus fields, push expectations on acceptance.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      sb.delete();
    end else begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(1) << mon_e.idx);
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          check("rsp_latency", cyc - mon_e.acc_cyc, mon_e.lat);
        end
      end
      if (transfer) begin
        if (sb.size() == 0) begin
          check("xfer_unexpected", 32'(transfer), 32'h0);
        end else begin
          check("xfer_latency", cyc - sb[0].acc_cyc, 32'd1);
          check("swrite", 32'(SWRITE), 32'(sb[0].write));
          check("saddr", SADDR, sb[0].addr);
          check("swdata", SWDATA, sb[0].wdata);
          check("sstrb", 32'(SSTRB), 32'(sb[0].strb));
          check("sprot", 32'(SPROT), 32'(sb[0].prot));
        end
      end
      if (req_ready != '0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        mon_g = 0;
        for (int k = 0; k < N; k++) if (req_ready[k]) mon_g = k;
        grants.push_back(mon_g);
        mon_e.idx     = mon_g;
        mon_e.write   = req_write[mon_g];
        mon_e.addr    = req_addr[32*mon_g +: 32];
        mon_e.wdata   = req_wdata[32*mon_g +: 32];
        mon_e.strb    = req_strb[4*mon_g +: 4];
        mon_e.prot    = req_prot[3*mon_g +: 3];
        mon_e.err     = stall || (mon_e.addr == 32'h100);
        mon_e.rdata   = 32'h0;
        if (!mon_e.write && !mon_e.err && model_mem.exists(mon_e.addr))
          mon_e.rdata = model_mem[mon_e.addr];
        if (mon_e.write && !mon_e.err) model_mem[mon_e.addr] = mon_e.wdata;
        mon_e.acc_cyc = cyc;
        mon_e.lat     = stall ? 32'd18 : 32'd3;
        sb.push_back(mon_e);
      end
    end
  end

  // APB slave model: setup on transfer, access next cycle; stall holds PREADY low.
  initial begin : slave
    int          sst;
    logic [31:0] s_addr, s_wdata;
    logic        s_wr, s_err;
    PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
    sst = 0; s_addr = '0; s_wdata = '0; s_wr = 0; s_err = 0;
    forever begin
      @(posedge PCLK);
      #2;
      if (!PRESETn) begin
        PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;
        sst = 0;
      end else begin
        case (sst)
          0: if (transfer) begin
               PSEL = 1; s_addr = SADDR; s_wr = SWRITE; s_wdata = SWDATA; sst = 1;
             end
          1: begin
               PENABLE = 1;
               if (!stall) begin
                 s_err   = (s_addr == 32'h100);
                 PREADY  = 1;
                 PSLVERR = s_err;
                 PRDATA  = (!s_wr && !s_err && slave_mem.exists(s_addr)) ? slave_mem[s_addr] : 32'h0;
                 if (s_wr && !s_err) slave_mem[s_addr] = s_wdata;
                 sst = 3;
               end else begin
                 sst = 2;
               end
             end
          2: if (!stall) begin
               PREADY = 1; PSLVERR = 1; PRDATA = 32'hBAD0_BAD0; sst = 3;
             end
          default: begin
               PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0; sst = 0;
             end
        endcase
      end
    end
  end

  task automatic set_req(input int unsigned i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_write[i]       = wr;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = d;
    req_strb[4*i +: 4]    = s;
    req_prot[3*i +: 3]    = p;
  endtask

  task automatic do_req(input int unsigned i, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    logic got;
    got = 1'b0;
    @(posedge PCLK); #1;
    set_req(i, wr, a, d, s, p);
    req_valid[i] = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge PCLK);
      got = req_ready[i];
    end
    check("accept", 32'(got), 32'd1);
    @(posedge PCLK); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge PCLK); #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge PCLK);
    #1;
  endtask

  // Main stimulus sequence.
  initial begin : stim
    logic        got;
    int unsigned g;
    PRESETn = 0; stall = 0; got = 0; g = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
    set_req(0, 1'b1, 32'h10, 32'h1111_0000, 4'hF, 3'h0);
    set_req(1, 1'b1, 32'h20, 32'h2222_0000, 4'h3, 3'h1);
    req_valid = 2'b11;
    repeat (2) @(negedge PCLK);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_transfer", 32'(transfer), 32'h0);
    check("rst_saddr", SADDR, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_tflag", 32'(timeout_flag), 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1;

    // Contention: both requesters valid continuously, four grants.
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
        @(negedge PCLK);
        got = (req_ready != '0);
        if (got) g = req_ready[1] ? 1 : 0;
      end
      check("contention_accept", 32'(got), 32'd1);
      @(posedge PCLK); #1;
      if (t == 3) req_valid = '0;
      else set_req(g, 1'b1, 32'h40 + 32'(t*4), 32'hC0DE_0000 + 32'(t), 4'hF, 3'(t));
    end
    drain();
    check("grant_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < 4; k++) if (k < grants.size()) check("grant_order", grants[k], 32'(k % 2));

    // Single write then readback by the other requester.
    do_req(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 3'h0);
    drain();
    do_req(1, 1'b0, 32'h4, 32'h0, 4'hF, 3'h2);
    drain();

    // Slave error on read of 0x100.
    do_req(0, 1'b0, 32'h100, 32'h0, 4'hF, 3'h0);
    drain();
    check("tflag_after_slverr", 32'(timeout_flag), 32'h0);

    // Stall until watchdog expiry, then a stray PREADY, then a normal request.
    stall = 1;
    do_req(0, 1'b0, 32'h8, 32'h0, 4'hF, 3'h0);
    drain();
    check("tflag_after_timeout", 32'(timeout_flag), 32'h1);
    stall = 0;
    repeat (4) @(negedge PCLK);
    #1;
    check("tflag_sticky", 32'(timeout_flag), 32'h1);
    do_req(1, 1'b0, 32'h4, 32'h0, 4'hF, 3'h0);
    drain();

    // Reset in the middle of WAIT; rr pointer was left at 1 by this grant.
    stall = 1;
    do_req(0, 1'b0, 32'hC, 32'h0, 4'hF, 3'h0);
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_transfer", 32'(transfer), 32'h0);
    check("midrst_saddr", SADDR, 32'h0);
    check("midrst_swrite", 32'(SWRITE), 32'h0);
    check("midrst_rsp_err", 32'(rsp_err), 32'h0);
    check("midrst_tflag", 32'(timeout_flag), 32'h0);
    repeat (2) begin
      @(negedge PCLK);
      check("midrst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    stall = 0;
    grants.delete();
    set_req(0, 1'b0, 32'h4, 32'h0, 4'hF, 3'h0);
    set_req(1, 1'b1, 32'h30, 32'h3030_3030, 4'h5, 3'h4);
    req_valid = 2'b11;
    check("midrst_req_ready", 32'(req_ready), 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1;
    for (int t = 0; t < 2; t++) begin
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
        @(negedge PCLK);
        got = (req_ready != '0);
        if (got) g = req_ready[1] ? 1 : 0;
      end
      check("post_rst_accept", 32'(got), 32'd1);
      @(posedge PCLK); #1;
      req_valid[g] = 1'b0;
    end
    drain();
    check("post_rst_grants", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      check("post_rst_first", grants[0], 32'd0);
      check("post_rst_second", grants[1], 32'd1);
    end
    check("post_rst_tflag", 32'(timeout_flag), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master transfer port (SWRITE/SADDR/SWDATA/SSTRB/SPROT/transfer) among NUM_REQ requesters, with round-robin arbitration.
- Sequences one transfer at a time. Completion is detected from the APB bus signals, and read data or an error is returned to the granted requester.
- A watchdog terminates transfers that stall.
- Sits between the CPU/DMA-side request sources and the apb_wrapper master input.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT, 16, WAIT-state cycles allowed before a forced error response (≥2).

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*32  packed address, requester i at [32i+31:32i]
- req_wdata  in  NUM_REQ*32  packed write data
- req_strb  in  NUM_REQ*4  packed byte strobes
- req_prot  in  NUM_REQ*3  packed protection
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_rdata  out  32  read data, shared, valid with rsp_valid
- rsp_err  out  1  error, valid with rsp_valid
- SWRITE  out  1  to apb_wrapper
- SADDR  out  32  to apb_wrapper
- SWDATA  out  32  to apb_wrapper
- SSTRB  out  4  to apb_wrapper
- SPROT  out  3  to apb_wrapper
- transfer  out  1  one-cycle start pulse to apb_wrapper
- PSEL, PENABLE, PREADY, PSLVERR  in  1 each  monitored APB bus
- PRDATA  in  32  monitored APB read data
- timeout_flag  out  1  sticky, set on any watchdog expiry

Behaviour:
- Reset (async, PRESETn=0): all outputs 0; FSM=IDLE; rr pointer=0; watchdog=0; timeout_flag=0.
- Reset mid-transfer aborts immediately; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first set bit searching from rr pointer upward, modulo NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational from req_valid and state).
  - At the edge: latch requester g's fields into SWRITE/SADDR/SWDATA/SSTRB/SPROT; store g; rr pointer←(g+1) mod NUM_REQ; go to ISSUE.
- ISSUE: transfer=1 for exactly this cycle; watchdog cleared; go to WAIT.
- WAIT:
  - Completion = PSEL & PENABLE & PREADY.
  - On completion: capture PRDATA (reads only; writes capture 0) and PSLVERR; go to RESP.
  - Otherwise watchdog increments. When watchdog reaches TIMEOUT-1 without completion: rsp_err captured as 1, rdata captured as 0, timeout_flag←1, go to RESP.
- RESP: rsp_valid[g]=1 for one cycle with rsp_rdata/rsp_err; go to IDLE. A new grant is possible on the following cycle.
- Bus outputs S* hold their latched values from acceptance through RESP. They are not cleared on return to IDLE.
- Completions seen in IDLE, ISSUE or RESP (e.g. a late completion after timeout) are ignored.
- Requesters must hold their fields stable while req_valid is high and until req_ready. req_valid dropped before grant is legal (request withdrawn).
- Minimum request-to-response latency: accept cycle + ISSUE + ≥1 WAIT + RESP. Back-to-back throughput is one transfer per (4 + wait-states) cycles.
- Fairness: a requester waiting while another is granted is served within NUM_REQ grants.
- timeout_flag clears only on reset.

Test Plan:
- Single write: req0 write addr 0x4, data 0xDEADBEEF, strb 0xF, slave PREADY immediate → req_ready[0] pulse; transfer pulses 1 cycle later with SADDR=0x4, SWDATA=0xDEADBEEF, SWRITE=1; rsp_valid[0]=1, rsp_err=0.
- Readback: req1 read addr 0x4 → rsp_valid[1]=1, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Contention: req0 and req1 both valid continuously from reset, 4 transfers → grant order 0,1,0,1; exactly one req_ready per transfer.
- Slave error: slave returns PSLVERR=1 on read of 0x100 → rsp_err=1 with rsp_valid for that requester; timeout_flag stays 0.
- Stall: PREADY held 0, TIMEOUT=16 → rsp_valid with rsp_err=1, rsp_rdata=0 sixteen cycles after the WAIT entry; timeout_flag=1; a later stray PREADY is ignored and the next request proceeds normally.
- Reset mid-WAIT: PRESETn low during WAIT → all outputs 0 immediately, no rsp_valid; after release, a fresh request completes normally and rr pointer starts at 0.
